linebuffer_scanout: RTL and testbench

- Read side of the sprite/tile line-buffer path.
- Owns a ping-pong pair of 640x16 line buffers:
  - Draw engines write the back bank through the draw port (wren / pixel_hcount / data).
  - The VGA timing side reads the front bank one pixel per pixel strobe.
- Swaps banks at each end of line, clears pixels behind the read pointer, and issues the per-line draw_start/draw_row request to the draw engines.

---
 rtl/vga_pkg.sv | 22 ++
 rtl/linebuffer_scanout_if.sv | 29 ++
 rtl/linebuffer_ram.sv | 25 ++
 rtl/linebuffer_scanout.sv | 107 ++++++++++
 tb/tb_linebuffer_scanout.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing constants, pixel type and scanout state encoding
// for the line-buffer path.
package vga_pkg;
    localparam int         H_DEPTH  = 640;
    localparam logic [9:0] H_ACTIVE = 10'd640;
    localparam logic [9:0] V_ACTIVE = 10'd480;
    localparam logic [9:0] V_TOTAL  = 10'd525;
    localparam logic [9:0] V_PRIME  = V_TOTAL - 10'd2;

    typedef logic [15:0] pixel_t;
    localparam pixel_t BG_COLOR = 16'h0000;

    typedef enum logic [1:0] {WAIT_FRAME, PRIME, RUN} state_t;

    // Line two ahead of v, wrapped at the frame height.
    function automatic logic [9:0] next_row(input logic [9:0] v);
        logic [10:0] r;
        r = {1'b0, v} + 11'd2;
        r = (r >= {1'b0, V_TOTAL}) ? r - {1'b0, V_TOTAL} : r;
        return r[9:0];
    endfunction
endpackage

// File: rtl/linebuffer_scanout_if.sv
// linebuffer_scanout_if: draw-port and VGA-side signals of the scanout block;
// slave is the scanout, master is the draw engines plus VGA timing.
interface linebuffer_scanout_if;
    import vga_pkg::*;
    logic       wren;
    logic [9:0] pixel_hcount;
    pixel_t     data;
    logic       draw_busy;
    logic       vga_pixel_en;
    logic [9:0] vga_hcount;
    logic [9:0] vga_vcount;
    logic       vga_line_end;
    logic       draw_start;
    logic [9:0] draw_row;
    pixel_t     rgb_out;
    logic       rgb_valid;
    logic       underrun;

    modport slave (
        input  wren, pixel_hcount, data, draw_busy,
        input  vga_pixel_en, vga_hcount, vga_vcount, vga_line_end,
        output draw_start, draw_row, rgb_out, rgb_valid, underrun
    );
    modport master (
        output wren, pixel_hcount, data, draw_busy,
        output vga_pixel_en, vga_hcount, vga_vcount, vga_line_end,
        input  draw_start, draw_row, rgb_out, rgb_valid, underrun
    );
endinterface

// File: rtl/linebuffer_ram.sv
// linebuffer_ram: one line bank, simple dual-port with a single write port
// and a registered read port. Contents are never reset.
module linebuffer_ram
    import vga_pkg::*;
#(
    parameter int DEPTH = H_DEPTH
) (
    input  logic       clk,
    input  logic       we,
    input  logic [9:0] waddr,
    input  pixel_t     wdata,
    input  logic       re,
    input  logic [9:0] raddr,
    output pixel_t     rdata
);
    pixel_t mem [0:DEPTH-1];
    pixel_t rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/linebuffer_scanout.sv
// linebuffer_scanout: ping-pong line-buffer read side; swaps banks per line,
// clears behind the read pointer and requests the next row. Option: LB_UNDERRUN_CNT_EN.
module linebuffer_scanout
    import vga_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    linebuffer_scanout_if.slave  lb
`ifdef LB_UNDERRUN_CNT_EN
    ,
    output logic [15:0]          underrun_count
`endif
);
    state_t     state_q, state_d;
    logic       front_q, front_d;
    logic       draw_start_q, draw_start_d;
    logic [9:0] draw_row_q, draw_row_d;
    logic       underrun_q, underrun_d;
    logic       rgb_valid_q, rgb_valid_d;
    logic       rgb_sel_q, rgb_sel_d;
    logic       rd_bank_q, rd_bank_d;
    logic       clr_q, clr_d;
    logic [9:0] clr_addr_q, clr_addr_d;

    logic       running, swap, prime, rd_act, fwd;
    logic [9:0] row;
    pixel_t     rdata [2];

    always_comb begin
        running      = state_q != WAIT_FRAME;
        swap         = lb.vga_line_end && running;
        prime        = lb.vga_line_end && state_q == WAIT_FRAME && lb.vga_vcount == V_PRIME;
        rd_act       = lb.vga_pixel_en && running && lb.vga_hcount < H_ACTIVE && lb.vga_vcount < V_ACTIVE;
        // A read of the pixel cleared last cycle must see the clear, not the stale RAM word.
        fwd          = clr_q && clr_addr_q == lb.vga_hcount && rd_bank_q == front_q;
        row          = next_row(lb.vga_vcount);
        state_d      = prime ? PRIME : (state_q == PRIME && lb.vga_line_end) ? RUN : state_q;
        front_d      = front_q ^ swap;
        draw_start_d = prime || (swap && row < V_ACTIVE);
        draw_row_d   = prime ? 10'd0 : draw_start_d ? row : draw_row_q;
        underrun_d   = underrun_q | (swap & lb.draw_busy);
        rgb_valid_d  = lb.vga_pixel_en && running;
        rgb_sel_d    = rgb_valid_d ? rd_act && !fwd : rgb_sel_q;
        rd_bank_d    = rd_act ? front_q : rd_bank_q;
        clr_d        = rd_act;
        clr_addr_d   = rd_act ? lb.vga_hcount : clr_addr_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= WAIT_FRAME;
            front_q      <= 1'b0;
            draw_start_q <= 1'b0;
            draw_row_q   <= '0;
            underrun_q   <= 1'b0;
            rgb_valid_q  <= 1'b0;
            rgb_sel_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            clr_q        <= 1'b0;
            clr_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            front_q      <= front_d;
            draw_start_q <= draw_start_d;
            draw_row_q   <= draw_row_d;
            underrun_q   <= underrun_d;
            rgb_valid_q  <= rgb_valid_d;
            rgb_sel_q    <= rgb_sel_d;
            rd_bank_q    <= rd_bank_d;
            clr_q        <= clr_d;
            clr_addr_q   <= clr_addr_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic       clr_b, draw_b;
        // Draw writes follow the current back bank, so a write coincident with
        // line_end lands in the pre-swap back bank.
        assign clr_b  = clr_q && rd_bank_q == 1'(b);
        assign draw_b = lb.wren && lb.pixel_hcount < H_ACTIVE && front_q != 1'(b);
        linebuffer_ram #(.DEPTH(H_DEPTH)) u_ram (
            .clk   (clk),
            .we    (clr_b || draw_b),
            .waddr (clr_b ? clr_addr_q : lb.pixel_hcount),
            .wdata (clr_b ? BG_COLOR : lb.data),
            .re    (rd_act && front_q == 1'(b)),
            .raddr (lb.vga_hcount),
            .rdata (rdata[b])
        );
    end

    assign lb.draw_start = draw_start_q;
    assign lb.draw_row   = draw_row_q;
    assign lb.rgb_valid  = rgb_valid_q;
    assign lb.rgb_out    = rgb_sel_q ? rdata[rd_bank_q] : BG_COLOR;
    assign lb.underrun   = underrun_q;

`ifdef LB_UNDERRUN_CNT_EN
    logic [15:0] ucnt_q, ucnt_d;
    assign ucnt_d = (swap && lb.draw_busy && ucnt_q != 16'hFFFF) ? ucnt_q + 16'd1 : ucnt_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ucnt_q <= '0;
        else        ucnt_q <= ucnt_d;
    end
    assign underrun_count = ucnt_q;
`endif
endmodule

// File: tb/tb_linebuffer_scanout.sv
// tb_linebuffer_scanout: directed plus random stimulus against an array model
// of the two banks, the displayed bank index and the row request rule.
module tb_linebuffer_scanout;
    import vga_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    linebuffer_scanout_if lb();
`ifdef LB_UNDERRUN_CNT_EN
    logic [15:0] ucnt;
`endif

    linebuffer_scanout dut (
        .clk   (clk),
        .reset (rst_n),
        .lb    (lb)
`ifdef LB_UNDERRUN_CNT_EN
        ,
        .underrun_count (ucnt)
`endif
    );

    int total = 0;
    int fails = 0;
    logic [15:0] mdl [2][640];
    int   mfront = 0;
    bit   primed = 0;
    bit   mund = 0;
    int   mcnt = 0;
    logic [15:0] last_exp = 16'h0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int a, input logic [15:0] d);
        lb.wren = 1'b1; lb.pixel_hcount = 10'(a); lb.data = d;
        tick;
        lb.wren = 1'b0;
        if (a < 640) mdl[1-mfront][a] = d;
    endtask

    task automatic rd(input int h, input int v);
        logic [15:0] e;
        bit act;
        lb.vga_pixel_en = 1'b1; lb.vga_hcount = 10'(h); lb.vga_vcount = 10'(v);
        tick;
        lb.vga_pixel_en = 1'b0;
        act = h < 640 && v < 480;
        if (!primed) begin
            chk("wait_valid", 32'(lb.rgb_valid), 32'd0);
            chk("wait_rgb", 32'(lb.rgb_out), 32'(BG_COLOR));
        end else begin
            e = act ? mdl[mfront][h] : BG_COLOR;
            chk("rd_valid", 32'(lb.rgb_valid), 32'd1);
            chk($sformatf("rd_rgb h=%0d v=%0d", h, v), 32'(lb.rgb_out), 32'(e));
            if (act) mdl[mfront][h] = BG_COLOR;
            last_exp = e;
        end
    endtask

    task automatic le(input int v, input bit busy, input int wa = -1, input logic [15:0] wd = 16'h0);
        int row;
        bit pulse;
        lb.vga_line_end = 1'b1; lb.vga_vcount = 10'(v); lb.draw_busy = busy;
        if (wa >= 0) begin
            lb.wren = 1'b1; lb.pixel_hcount = 10'(wa); lb.data = wd;
            if (wa < 640) mdl[1-mfront][wa] = wd;
        end
        tick;
        lb.vga_line_end = 1'b0; lb.draw_busy = 1'b0; lb.wren = 1'b0;
        if (!primed) begin
            pulse = (v == 523);
            row = 0;
            primed = pulse;
        end else begin
            mfront = 1 - mfront;
            row = (v + 2) % 525;
            pulse = row < 480;
            if (busy) begin
                mund = 1;
                if (mcnt < 65535) mcnt++;
            end
        end
        chk($sformatf("draw_start v=%0d", v), 32'(lb.draw_start), 32'(pulse));
        if (pulse) chk($sformatf("draw_row v=%0d", v), 32'(lb.draw_row), 32'(row));
        chk("underrun", 32'(lb.underrun), 32'(mund));
`ifdef LB_UNDERRUN_CNT_EN
        chk("underrun_count", 32'(ucnt), 32'(mcnt));
`endif
        tick;
        chk("draw_start_single", 32'(lb.draw_start), 32'd0);
    endtask

    task automatic chk_reset;
        chk("rst_draw_start", 32'(lb.draw_start), 32'd0);
        chk("rst_draw_row", 32'(lb.draw_row), 32'd0);
        chk("rst_rgb_out", 32'(lb.rgb_out), 32'(BG_COLOR));
        chk("rst_rgb_valid", 32'(lb.rgb_valid), 32'd0);
        chk("rst_underrun", 32'(lb.underrun), 32'd0);
`ifdef LB_UNDERRUN_CNT_EN
        chk("rst_underrun_count", 32'(ucnt), 32'd0);
`endif
    endtask

    initial begin
        lb.wren = 1'b0; lb.pixel_hcount = '0; lb.data = '0; lb.draw_busy = 1'b0;
        lb.vga_pixel_en = 1'b0; lb.vga_hcount = '0; lb.vga_vcount = '0; lb.vga_line_end = 1'b0;
        for (int b = 0; b < 2; b++) for (int a = 0; a < 640; a++) mdl[b][a] = 'x;
        tick; tick;
        chk_reset;
        rst_n = 1'b1;
        tick;
        // First frame: nothing shown until priming.
        rd(5, 5);
        le(10, 0);
        le(523, 0);
        rd(5, 524);
        for (int a = 0; a < 640; a++) wr(a, 16'($urandom));
        le(524, 0);
        for (int a = 0; a < 640; a++) wr(a, 16'($urandom));
        // Output holds with no strobe.
        rd(3, 0);
        tick;
        chk("hold_valid", 32'(lb.rgb_valid), 32'd0);
        chk("hold_rgb", 32'(lb.rgb_out), 32'(last_exp));
        // Random mix of reads, writes and line ends.
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 5) rd(int'($urandom_range(0, 700)), ($urandom_range(0, 3) == 0) ? int'($urandom_range(480, 524)) : int'($urandom_range(0, 479)));
            else if (r < 8) wr(int'($urandom_range(0, 700)), 16'($urandom));
            else le(int'($urandom_range(0, 524)), 0);
        end
        // Written pixel shows after swap, then gets cleared behind the read.
        wr(5, 16'hF800);
        le(0, 0);
        rd(5, 1);
        chk("red_pixel", 32'(lb.rgb_out), 32'h0000F800);
        le(1, 0);
        le(2, 0);
        rd(5, 3);
        chk("cleared_pixel", 32'(lb.rgb_out), 32'(BG_COLOR));
        // Out-of-range write is dropped; sweep the whole line.
        wr(640, 16'h07E0);
        le(3, 0);
        for (int h = 0; h < 640; h++) rd(h, 4);
        // Write coincident with line_end goes to the pre-swap back bank.
        le(5, 0, 7, 16'h1234);
        rd(7, 7);
        chk("wr_at_swap", 32'(lb.rgb_out), 32'h00001234);
        // Row request boundaries.
        le(477, 0);
        le(478, 0);
        le(523, 0);
        // Underrun is sticky and counted.
        le(10, 1);
        le(11, 1);
        le(12, 1);
        le(13, 0);
        chk("underrun_sticky", 32'(lb.underrun), 32'd1);
`ifdef LB_UNDERRUN_CNT_EN
        chk("underrun_count3", 32'(ucnt), 32'd3);
`endif
        // Mid-line reset returns to waiting for the frame.
        lb.vga_pixel_en = 1'b1; lb.vga_hcount = 10'd20; lb.vga_vcount = 10'd20;
        #2 rst_n = 1'b0;
        #1 chk_reset;
        lb.vga_pixel_en = 1'b0;
        tick;
        rst_n = 1'b1;
        primed = 0; mund = 0; mcnt = 0; mfront = 0;
        tick;
        rd(5, 5);
        le(100, 1);
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
